count_dir_ctrl: RTL and testbench

Direction controller that sits directly upstream of the 3-bit up/down counter and drives its mode input `m` (0 = count up, 1 = count down). It debounces a raw direction pushbutton and toggles `m` on each clean press. In auto mode it reads the counter's `q` back and reverses `m` one cycle before each terminal count, so the counter runs a triangle sequence 0..7..0 with no wrap.

---
 rtl/count_dir_pkg.sv | 19 +
 rtl/btn_debounce.sv | 93 +++++++++
 rtl/count_dir_ctrl.sv | 63 ++++++
 tb/tb_count_dir_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/count_dir_pkg.sv
// Shared types and helpers for the counter direction controller.
// Holds the debounce state encoding and the terminal-count helper.
package count_dir_pkg;

  typedef enum logic [1:0] {
    DB_LOW  = 2'd0,
    DB_RISE = 2'd1,
    DB_HIGH = 2'd2,
    DB_FALL = 2'd3
  } db_state_t;

  localparam int DEB_CNT_W = 8;

  // Terminal count of an unsigned counter of width cw.
  function automatic int unsigned cnt_max(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus four-state debouncer for the direction button.
// Emits the debounced level and a single-cycle press strobe on accepted rises.
module btn_debounce
  import count_dir_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic btn_i,
  output logic btn_db_o,
  output logic press_o
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 s1_q, s2_q;
  db_state_t            state_q, state_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 btn_db_q, btn_db_d;
  logic                 press_d;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= DB_LOW;
      cnt_q    <= '0;
      btn_db_q <= 1'b0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  // cnt holds how many consecutive samples have disagreed with the accepted level.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    btn_db_d = btn_db_q;
    press_d  = 1'b0;
    unique case (state_q)
      DB_LOW: begin
        if (s2_q) begin
          state_d = DB_RISE;
          cnt_d   = DEB_CNT_W'(1);
        end
      end
      DB_RISE: begin
        if (!s2_q) begin
          state_d = DB_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DB_HIGH;
          cnt_d    = '0;
          btn_db_d = 1'b1;
          press_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DEB_CNT_W'(1);
        end
      end
      DB_HIGH: begin
        if (!s2_q) begin
          state_d = DB_FALL;
          cnt_d   = DEB_CNT_W'(1);
        end
      end
      DB_FALL: begin
        if (s2_q) begin
          state_d = DB_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DB_LOW;
          cnt_d    = '0;
          btn_db_d = 1'b0;
        end else begin
          cnt_d = cnt_q + DEB_CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_db_o = btn_db_q;
  assign press_o  = press_d;

endmodule

// File: rtl/count_dir_ctrl.sv
// Drives the up/down counter's mode bit: toggles on clean button presses and,
// in auto mode, reverses one cycle ahead of each terminal count.
module count_dir_ctrl
  import count_dir_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          btn,
  input  logic          auto_en,
  input  logic [CW-1:0] q,
  output logic          m,
  output logic          btn_db,
  output logic          dir_chg
);

  localparam logic [CW-1:0] MAX       = CW'(cnt_max(CW));
  localparam logic [CW-1:0] Q_PRE_TOP = MAX - CW'(1);
  localparam logic [CW-1:0] Q_PRE_BOT = CW'(1);

  logic press;
  logic af;
  logic toggle;
  logic m_q, m_d;
  logic dir_chg_q, dir_chg_d;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk_i   (clk),
    .clr_i   (clr),
    .btn_i   (btn),
    .btn_db_o(btn_db),
    .press_o (press)
  );

  // Flip on the edge where the counter lands on a terminal value, so it reverses next edge.
  assign af = auto_en & ((~m_q & (q == Q_PRE_TOP)) | (m_q & (q == Q_PRE_BOT)));

  // A press coinciding with an auto flip still yields a single inversion.
  assign toggle = press | af;

  always_comb begin
    m_d       = m_q ^ toggle;
    dir_chg_d = toggle;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      m_q       <= 1'b0;
      dir_chg_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      dir_chg_q <= dir_chg_d;
    end
  end

  assign m       = m_q;
  assign dir_chg = dir_chg_q;

endmodule

// File: tb/tb_count_dir_ctrl.sv
// Closed-loop bench: a 3-bit up/down counter driven by the DUT's m feeds q back,
// and a run-length reference model predicts m, btn_db and dir_chg every cycle.
module tb_count_dir_ctrl;

  localparam int DEB  = 4;
  localparam int CW   = 3;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr;
  logic          btn;
  logic          auto_en;
  logic [CW-1:0] q;
  logic          m;
  logic          btn_db;
  logic          dir_chg;

  always #5 clk = ~clk;

  count_dir_ctrl #(
    .DEB_CYCLES(DEB),
    .CW        (CW)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .btn    (btn),
    .auto_en(auto_en),
    .q      (q),
    .m      (m),
    .btn_db (btn_db),
    .dir_chg(dir_chg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: button history, accepted level, disagreement run length, direction.
  bit mm, mdb, mdc;
  bit hist1, hist2;
  int mrun;
  int cq;
  int prev_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    bit c, b, a, dut_m, press, af, tog;
    c      = clr;
    b      = btn;
    a      = auto_en;
    dut_m  = m;
    prev_q = cq;
    @(posedge clk);
    #1;
    if (c) begin
      mm = 0; mdb = 0; mdc = 0; hist1 = 0; hist2 = 0; mrun = 0; cq = 0;
    end else begin
      press = 0;
      if (hist2 != mdb) begin
        mrun++;
        if (mrun == DEB) begin
          mdb   = hist2;
          mrun  = 0;
          press = hist2;
        end
      end else begin
        mrun = 0;
      end
      af  = a && ((!mm && prev_q == MAXV - 1) || (mm && prev_q == 1));
      tog = press || af;
      mdc = tog;
      mm  = mm ^ tog;
      hist2 = hist1;
      hist1 = b;
      cq = dut_m ? (prev_q + MAXV) % (MAXV + 1) : (prev_q + 1) % (MAXV + 1);
    end
    q = cq[CW-1:0];
    chk("m", m, mm);
    chk("btn_db", btn_db, mdb);
    chk("dir_chg", dir_chg, mdc);
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1;
    repeat (n) tick();
    clr = 1'b0;
  endtask

  initial begin
    int first_edge, pulses, dbh, hold;
    mm = 0; mdb = 0; mdc = 0; hist1 = 0; hist2 = 0; mrun = 0; cq = 0; prev_q = 0;
    q = '0;
    btn = 1'b1;
    auto_en = 1'b0;

    // Reset held with the button already pressed, then the press re-qualifies.
    do_reset(3);
    first_edge = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (m && first_edge == 0) first_edge = i;
    end
    chk("press_edge", first_edge, 6);

    // Release, then a second clean press toggles back.
    btn = 1'b0;
    pulses = 0;
    repeat (12) begin tick(); if (dir_chg) pulses++; end
    chk("release_pulses", pulses, 0);
    btn = 1'b1;
    pulses = 0;
    repeat (10) begin tick(); if (dir_chg) pulses++; end
    chk("press2_pulses", pulses, 1);
    chk("press2_m", m, 0);

    // Glitchy button: 3 high, 1 low, 3 high never qualifies.
    btn = 1'b0;
    repeat (12) tick();
    pulses = 0;
    dbh = 0;
    for (int i = 0; i < 16; i++) begin
      btn = (i < 3 || (i >= 4 && i < 7)) ? 1'b1 : 1'b0;
      tick();
      if (dir_chg) pulses++;
      if (btn_db) dbh++;
    end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_db", dbh, 0);

    // Auto bounce from reset: triangle with flips at 7 and 0.
    btn = 1'b0;
    auto_en = 1'b1;
    do_reset(2);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("auto_nowrap", (prev_q == MAXV && cq == 0) || (prev_q == 0 && cq == MAXV), 0);
      if (dir_chg) begin
        pulses++;
        chk("auto_pulse_term", (cq == MAXV) || (cq == 0), 1);
      end
    end
    chk("auto_pulses", pulses, 4);

    // Press qualified on the same edge the counter steps 6 -> 7 going up.
    do_reset(2);
    tick();
    btn = 1'b1;
    repeat (6) tick();
    chk("simul_q", cq, MAXV);
    chk("simul_m", m, 1);
    pulses = 1;
    repeat (4) begin tick(); if (dir_chg) pulses++; end
    chk("simul_pulses", pulses, 1);

    // Late auto enable at q=7 going up: one wrap, then bounce at the next top.
    btn = 1'b0;
    auto_en = 1'b0;
    do_reset(2);
    repeat (7) tick();
    chk("late_pre_q", cq, MAXV);
    auto_en = 1'b1;
    tick();
    chk("late_wrap_q", cq, 0);
    chk("late_wrap_m", m, 0);
    repeat (6) tick();
    chk("late_q6", cq, MAXV - 1);
    tick();
    chk("late_flip_m", m, 1);
    chk("late_flip_q", cq, MAXV);

    // Randomized button holds, auto toggling and occasional resets.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
      clr = ($urandom_range(0, 199) == 0);
      tick();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
